// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared constants for the ALU decode stage:
//   - alu_ctrl codes driven to the execute-stage ALU
//   - alu_op classes produced by the main instruction decoder
//   - funct7 classes recognised by the ALU decoder
//   - state type of the decode-stage handshake FSM
// Optional feature macro used by the importing files: ALU_DECODE_MEXT_EN.
// -----------------------------------------------------------------------------
package alu_pkg;

    // ALU control codes
    localparam logic [3:0] CTRL_ADD  = 4'b0000;
    localparam logic [3:0] CTRL_SLL  = 4'b0001;
    localparam logic [3:0] CTRL_SLT  = 4'b0010;
    localparam logic [3:0] CTRL_SLTU = 4'b0011;
    localparam logic [3:0] CTRL_XOR  = 4'b0100;
    localparam logic [3:0] CTRL_SRA  = 4'b0101;
    localparam logic [3:0] CTRL_OR   = 4'b0110;
    localparam logic [3:0] CTRL_AND  = 4'b0111;
    localparam logic [3:0] CTRL_SUB  = 4'b1000;
    localparam logic [3:0] CTRL_SRL  = 4'b1101;

    // Main-decoder ALU classes
    localparam logic [1:0] ALUOP_ADD   = 2'b00;  // loads/stores: address add
    localparam logic [1:0] ALUOP_SUB   = 2'b01;  // branches: compare by subtract
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;  // decode from funct3/funct7
    localparam logic [1:0] ALUOP_SLTU  = 2'b11;  // unsigned compare

    // funct7 classes
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;  // sub / sra
    localparam logic [6:0] F7_MEXT = 7'b0000001;  // multiply/divide group

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'b00,
        ST_FULL     = 2'b01,
        ST_DIV_WAIT = 2'b10
    } state_t;

endpackage

// File: rtl/alu_ctrl_comb.sv
// -----------------------------------------------------------------------------
// alu_ctrl_comb
// Purely combinational ALU-control decoder.
// Ports:
//   opb5     in  opcode bit 5 (1 = R-type)
//   funct3   in  instruction funct3
//   funct7   in  instruction funct7
//   alu_op   in  main-decoder ALU class
//   alu_ctrl out ALU control code (0000 when illegal or M-extension)
//   illegal  out encoding not legal for the ALU
//   md_en    out op belongs to the M extension
// Macro ALU_DECODE_MEXT_EN: recognise R-type funct7=0000001 as M extension;
// without it that encoding is illegal and md_en stays 0.
// -----------------------------------------------------------------------------
module alu_ctrl_comb
    import alu_pkg::*;
(
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_ctrl,
    output logic       illegal,
    output logic       md_en
);

    logic       is_mext;
    logic [3:0] fn_ctrl;
    logic       fn_illegal;

`ifdef ALU_DECODE_MEXT_EN
    assign is_mext = opb5 & (funct7 == F7_MEXT);
`else
    assign is_mext = 1'b0;
`endif

    // Register-register and register-immediate decode by funct3
    always_comb begin
        fn_ctrl = CTRL_ADD;
        unique case (funct3)
            3'b000: fn_ctrl = (opb5 & funct7[5]) ? CTRL_SUB : CTRL_ADD;
            3'b001: fn_ctrl = CTRL_SLL;
            3'b010: fn_ctrl = CTRL_SLT;
            3'b011: fn_ctrl = CTRL_SLTU;
            3'b100: fn_ctrl = CTRL_XOR;
            3'b101: fn_ctrl = funct7[5] ? CTRL_SRA : CTRL_SRL;
            3'b110: fn_ctrl = CTRL_OR;
            3'b111: fn_ctrl = CTRL_AND;
        endcase
    end

    // For I-type ops funct7 is immediate bits, so only the shift forms check it
    always_comb begin
        fn_illegal = 1'b0;
        if (opb5 && (funct7 != F7_BASE) && (funct7 != F7_ALT))
            fn_illegal = 1'b1;
        if (opb5 && (funct7 == F7_ALT) && (funct3 != 3'b000) && (funct3 != 3'b101))
            fn_illegal = 1'b1;
        if ((funct3 == 3'b001) && (funct7 != F7_BASE))
            fn_illegal = 1'b1;
        if ((funct3 == 3'b101) && (funct7 != F7_BASE) && (funct7 != F7_ALT))
            fn_illegal = 1'b1;
    end

    always_comb begin
        alu_ctrl = CTRL_ADD;
        illegal  = 1'b0;
        md_en    = 1'b0;
        unique case (alu_op)
            ALUOP_ADD:  alu_ctrl = CTRL_ADD;
            ALUOP_SUB:  alu_ctrl = CTRL_SUB;
            ALUOP_SLTU: alu_ctrl = CTRL_SLTU;
            ALUOP_FUNCT: begin
                if (is_mext) begin
                    md_en = 1'b1;
                end else begin
                    illegal  = fn_illegal;
                    alu_ctrl = fn_illegal ? CTRL_ADD : fn_ctrl;
                end
            end
        endcase
    end

endmodule

// File: rtl/alu_decode_stage.sv
// -----------------------------------------------------------------------------
// alu_decode_stage
// Registered ALU decode stage with valid/ready handshake and divider occupancy.
// Ports:
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   flush               synchronous kill of the held or pending op
//   in_valid / in_ready upstream handshake
//   opb5, funct3, funct7, alu_op  instruction fields to decode
//   out_valid / out_ready         downstream handshake
//   alu_ctrl, md_en, md_op, illegal  registered decode results
//   busy                divider occupancy in progress
// Parameters: DIV_CYCLES (1..255) divide latency, CNT_W counter width.
// Macro ALU_DECODE_MEXT_EN: enables M-extension decode, the occupancy counter
// and the DIV_WAIT state; without it busy is tied 0 and DIV_WAIT is unreachable.
// -----------------------------------------------------------------------------
module alu_decode_stage
    import alu_pkg::*;
#(
    parameter int DIV_CYCLES = 32,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       flush,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       opb5,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic [1:0] alu_op,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] alu_ctrl,
    output logic       md_en,
    output logic [2:0] md_op,
    output logic       illegal,
    output logic       busy
);

    if (DIV_CYCLES < 1 || DIV_CYCLES > 255 || (2 ** CNT_W) <= DIV_CYCLES) begin : g_cfg_check
        $error("alu_decode_stage: DIV_CYCLES must be 1..255 and fit in CNT_W bits");
    end

    state_t     state;
    logic       ready_en;   // keeps in_ready low until the first edge after reset
    logic       accept;
    logic [3:0] dec_ctrl_p0;
    logic       dec_ill_p0;
    logic       dec_md_p0;

    // Stage p0: combinational decode of the incoming fields
    alu_ctrl_comb u_ctrl (
        .opb5     (opb5),
        .funct3   (funct3),
        .funct7   (funct7),
        .alu_op   (alu_op),
        .alu_ctrl (dec_ctrl_p0),
        .illegal  (dec_ill_p0),
        .md_en    (dec_md_p0)
    );

    assign in_ready = ready_en & ~flush &
                      ((state == ST_EMPTY) | ((state == ST_FULL) & out_ready));
    assign accept   = in_valid & in_ready;

`ifdef ALU_DECODE_MEXT_EN
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
    logic [CNT_W-1:0] cnt;
    logic             is_div_p0;
    assign is_div_p0 = dec_md_p0 & funct3[2];
`else
    assign busy = 1'b0;
`endif

    // Stage p1: registered handshake state and decode results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_EMPTY;
            ready_en  <= 1'b0;
            out_valid <= 1'b0;
            alu_ctrl  <= 4'b0000;
            md_en     <= 1'b0;
            md_op     <= 3'b000;
            illegal   <= 1'b0;
`ifdef ALU_DECODE_MEXT_EN
            busy      <= 1'b0;
            cnt       <= '0;
`endif
        end else begin
            ready_en <= 1'b1;
            if (flush) begin
                state     <= ST_EMPTY;
                out_valid <= 1'b0;
`ifdef ALU_DECODE_MEXT_EN
                busy      <= 1'b0;
                cnt       <= '0;
`endif
            end else begin
                case (state)
                    ST_EMPTY, ST_FULL: begin
                        if (accept) begin
                            alu_ctrl <= dec_ctrl_p0;
                            illegal  <= dec_ill_p0;
                            md_en    <= dec_md_p0;
                            md_op    <= dec_md_p0 ? funct3 : 3'b000;
`ifdef ALU_DECODE_MEXT_EN
                            // A one-cycle divide skips DIV_WAIT entirely
                            if (is_div_p0 && (DIV_LOAD != '0)) begin
                                state     <= ST_DIV_WAIT;
                                out_valid <= 1'b0;
                                busy      <= 1'b1;
                                cnt       <= DIV_LOAD;
                            end else
`endif
                            begin
                                state     <= ST_FULL;
                                out_valid <= 1'b1;
                            end
                        end else if ((state == ST_FULL) && out_ready) begin
                            state     <= ST_EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
`ifdef ALU_DECODE_MEXT_EN
                    // Leave on the edge where the counter reaches zero so that
                    // out_valid appears DIV_CYCLES edges after acceptance
                    ST_DIV_WAIT: begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            state     <= ST_FULL;
                            out_valid <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
`endif
                    default: begin
                        state     <= ST_EMPTY;
                        out_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
`timescale 1ns/1ps
module tb_alu_decode_stage;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       opb5 = 1'b0;
    logic [2:0] funct3 = 3'b000;
    logic [6:0] funct7 = 7'b0000000;
    logic [1:0] alu_op = 2'b00;
    logic       in_ready, out_valid, md_en, illegal, busy;
    logic [3:0] alu_ctrl;
    logic [2:0] md_op;

    always #5 clk = ~clk;

    alu_decode_stage #(.DIV_CYCLES(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opb5      (opb5),
        .funct3    (funct3),
        .funct7    (funct7),
        .alu_op    (alu_op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_ctrl  (alu_ctrl),
        .md_en     (md_en),
        .md_op     (md_op),
        .illegal   (illegal),
        .busy      (busy)
    );

    typedef struct {
        logic       opb5;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [1:0] aop;
        logic [3:0] ctrl;
        logic       md;
        logic [2:0] mop;
        logic       ill;
    } vec_t;

    typedef struct {
        logic [3:0] ctrl;
        logic       md;
        logic [2:0] mop;
        logic       ill;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur_exp;
    int   n_chk = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input logic o, input logic [2:0] f3, input logic [6:0] f7,
                                input logic [1:0] aop, input logic [3:0] ctrl,
                                input logic md, input logic [2:0] mop, input logic ill);
        vec_t v;
        v.opb5 = o; v.f3 = f3; v.f7 = f7; v.aop = aop;
        v.ctrl = ctrl; v.md = md; v.mop = mop; v.ill = ill;
        return v;
    endfunction

    // Scoreboard: push on accept, pop on transfer; also check hold stability
    logic       hold_prev = 1'b0;
    logic [3:0] ctrl_prev;
    logic       md_prev, ill_prev;
    logic [2:0] mop_prev;

    always @(negedge clk) begin
        if (rst_n) begin
            if (hold_prev) begin
                check("hold_valid", out_valid, 1'b1);
                check("hold_ctrl", alu_ctrl, ctrl_prev);
                check("hold_md_op", md_op, mop_prev);
                check("hold_md_en", md_en, md_prev);
                check("hold_illegal", illegal, ill_prev);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", out_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("alu_ctrl", alu_ctrl, e.ctrl);
                    check("md_en", md_en, e.md);
                    check("md_op", md_op, e.mop);
                    check("illegal", illegal, e.ill);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(cur_exp);
            hold_prev = out_valid && !out_ready && !flush;
            ctrl_prev = alu_ctrl;
            md_prev   = md_en;
            mop_prev  = md_op;
            ill_prev  = illegal;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic apply(input vec_t v);
        opb5 = v.opb5; funct3 = v.f3; funct7 = v.f7; alu_op = v.aop;
        cur_exp.ctrl = v.ctrl; cur_exp.md = v.md; cur_exp.mop = v.mop; cur_exp.ill = v.ill;
        in_valid = 1'b1;
    endtask

    // Returns at posedge+1 of the accepting edge with in_valid dropped
    task automatic send(input vec_t v);
        apply(v);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        check("send_timeout", in_ready, 1'b1);
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk); #1;
        check(name, exp_q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_out_valid"}, out_valid, 1'b0);
        check({tag, "_alu_ctrl"}, alu_ctrl, 4'b0000);
        check({tag, "_md_en"}, md_en, 1'b0);
        check({tag, "_md_op"}, md_op, 3'b000);
        check({tag, "_illegal"}, illegal, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_in_ready"}, in_ready, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[$];
        vec_t v_add, v_sub, v_srai, v_or, v_and, v_divu;
        v_add  = mk(1'b1, 3'b000, 7'b0000000, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b0);
        v_sub  = mk(1'b1, 3'b000, 7'b0100000, 2'b10, 4'b1000, 1'b0, 3'b000, 1'b0);
        v_srai = mk(1'b0, 3'b101, 7'b0100000, 2'b10, 4'b0101, 1'b0, 3'b000, 1'b0);
        v_or   = mk(1'b1, 3'b110, 7'b0000000, 2'b10, 4'b0110, 1'b0, 3'b000, 1'b0);
        v_and  = mk(1'b1, 3'b111, 7'b0000000, 2'b10, 4'b0111, 1'b0, 3'b000, 1'b0);
`ifdef ALU_DECODE_MEXT_EN
        v_divu = mk(1'b1, 3'b101, 7'b0000001, 2'b10, 4'b0000, 1'b1, 3'b101, 1'b0);
`else
        v_divu = mk(1'b1, 3'b101, 7'b0000001, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1);
`endif

        tbl.push_back(v_add);
        tbl.push_back(v_sub);
        tbl.push_back(v_srai);
        tbl.push_back(mk(1'b0, 3'b101, 7'b0000000, 2'b10, 4'b1101, 1'b0, 3'b000, 1'b0)); // srli
        tbl.push_back(mk(1'b1, 3'b001, 7'b0000000, 2'b10, 4'b0001, 1'b0, 3'b000, 1'b0)); // sll
        tbl.push_back(mk(1'b1, 3'b010, 7'b0000000, 2'b10, 4'b0010, 1'b0, 3'b000, 1'b0)); // slt
        tbl.push_back(mk(1'b0, 3'b011, 7'b1010101, 2'b10, 4'b0011, 1'b0, 3'b000, 1'b0)); // sltiu
        tbl.push_back(mk(1'b1, 3'b100, 7'b0000000, 2'b10, 4'b0100, 1'b0, 3'b000, 1'b0)); // xor
        tbl.push_back(v_or);
        tbl.push_back(v_and);
        tbl.push_back(mk(1'b0, 3'b000, 7'b0100000, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b0)); // addi
        tbl.push_back(mk(1'b1, 3'b111, 7'b1111111, 2'b00, 4'b0000, 1'b0, 3'b000, 1'b0)); // load
        tbl.push_back(mk(1'b1, 3'b001, 7'b1111111, 2'b01, 4'b1000, 1'b0, 3'b000, 1'b0)); // branch
        tbl.push_back(mk(1'b0, 3'b110, 7'b0000001, 2'b11, 4'b0011, 1'b0, 3'b000, 1'b0)); // class 11
        tbl.push_back(mk(1'b0, 3'b001, 7'b0100000, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1)); // slli bad
        tbl.push_back(mk(1'b1, 3'b000, 7'b1111111, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1)); // bad f7
        tbl.push_back(mk(1'b1, 3'b110, 7'b0100000, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1)); // or+alt
        tbl.push_back(mk(1'b0, 3'b101, 7'b0000010, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1)); // bad shift
`ifdef ALU_DECODE_MEXT_EN
        tbl.push_back(mk(1'b1, 3'b000, 7'b0000001, 2'b10, 4'b0000, 1'b1, 3'b000, 1'b0)); // mul
        tbl.push_back(mk(1'b1, 3'b011, 7'b0000001, 2'b10, 4'b0000, 1'b1, 3'b011, 1'b0)); // mulhu
        tbl.push_back(mk(1'b1, 3'b100, 7'b0000001, 2'b10, 4'b0000, 1'b1, 3'b100, 1'b0)); // div
        tbl.push_back(v_and);
`else
        tbl.push_back(mk(1'b1, 3'b000, 7'b0000001, 2'b10, 4'b0000, 1'b0, 3'b000, 1'b1)); // mul
`endif
        tbl.push_back(v_divu);

        // Reset state and release
        #3;
        check_all_zero("reset");
        #9;                 // t=12, between edges
        rst_n = 1'b1;
        #1;
        check("ready_before_edge", in_ready, 1'b0);
        @(negedge clk);
        check("ready_after_edge", in_ready, 1'b1);
        @(posedge clk); #1;

        // First op: add, latency 1, then drain to EMPTY
        send(v_add);
        @(negedge clk);
        check("add_valid", out_valid, 1'b1);
        @(negedge clk);
        check("add_drained", out_valid, 1'b0);
        @(posedge clk); #1;

        // Back-to-back sub then srai
        apply(v_sub);
        @(negedge clk);
        check("b2b_ready0", in_ready, 1'b1);
        @(posedge clk); #1;
        apply(v_srai);
        @(negedge clk);
        check("b2b_ready1", in_ready, 1'b1);
        check("b2b_valid0", out_valid, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_valid1", out_valid, 1'b1);
        drain("b2b_drain");

        // Table sweep with continuous valid
        foreach (tbl[i]) send(tbl[i]);
        drain("table_drain");

        // Back-pressure: or held for 3 cycles
        out_ready = 1'b0;
        send(v_or);
        in_valid = 1'b1;    // offered but must not be taken
        cur_exp.ctrl = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", out_valid, 1'b1);
            check("bp_ctrl", alu_ctrl, 4'b0110);
            check("bp_in_ready", in_ready, 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", out_valid, 1'b1);
        @(negedge clk);
        check("bp_single", out_valid, 1'b0);
        drain("bp_drain");

`ifdef ALU_DECODE_MEXT_EN
        // Divide occupancy: 3 busy cycles, valid on 4th edge
        send(v_divu);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("div_busy", busy, 1'b1);
            check("div_no_valid", out_valid, 1'b0);
            check("div_in_ready", in_ready, 1'b0);
        end
        @(negedge clk);
        check("div_valid", out_valid, 1'b1);
        check("div_busy_done", busy, 1'b0);
        check("div_md_op", md_op, 3'b101);
        drain("div_drain");

        // Flush on 2nd busy cycle
        send(v_divu);
        @(negedge clk);
        check("fl_busy1", busy, 1'b1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl_busy2", busy, 1'b1);
        check("fl_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("fl_no_valid", out_valid, 1'b0);
            check("fl_no_busy", busy, 1'b0);
        end
        check("fl_ready", in_ready, 1'b1);
        @(posedge clk); #1;

        // Reset in the middle of DIV_WAIT
        send(v_divu);
        @(negedge clk);
        check("rst_div_busy", busy, 1'b1);
`else
        // Reset while an op is held
        out_ready = 1'b0;
        send(v_and);
        @(negedge clk);
        check("rst_hold_valid", out_valid, 1'b1);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("rst_mid");
        exp_q.delete();
        out_ready = 1'b1;
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(v_sub);
        @(negedge clk);
        check("post_rst_valid", out_valid, 1'b1);
        drain("post_rst_drain");

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
